// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults and control encodings for the CPU pipeline registers
package pipe_pkg;

    localparam int WORD_W_DEF  = 32;
    localparam int RD_W_DEF    = 5;
    localparam int WEN_BIT_DEF = 0;

    // MemtoReg source select carried in the control field
    typedef enum logic [1:0] {
        MTR_ALU = 2'b00,
        MTR_MEM = 2'b01,
        MTR_PC4 = 2'b10
    } mtr_e;

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// rtl/pipe_stage_reg_skid.sv - single holding entry used as the skid slot of pipe_stage_reg
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Clear beats load; payload is kept on clear since it is don't-care once invalid
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with flush and stall counter; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int N_WORDS = 3,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int CTRL_W  = 3,
    parameter int WEN_BIT = WEN_BIT_DEF,
    parameter int RD_W    = RD_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [RD_W-1:0]           in_rd,
    input  logic [N_WORDS*WORD_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [RD_W-1:0]           out_rd,
    output logic [N_WORDS*WORD_W-1:0] out_data,
    output logic                      out_wen,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int DW = N_WORDS * WORD_W;
    localparam int EW = CTRL_W + RD_W + DW;

    logic [EW-1:0]    in_entry;
    logic [EW-1:0]    main_q, main_d;
    logic             main_valid_q, main_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, consume;

    assign in_entry = {in_ctrl, in_rd, in_data};
    assign accept   = in_valid & in_ready;
    assign consume  = main_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic          skid_valid;
    logic [EW-1:0] skid_entry;
    logic          skid_load, skid_clear;

    // A beat arriving while main is held parks in skid; skid drains on the next consume
    assign in_ready   = ~skid_valid;
    assign skid_load  = accept & main_valid_q & ~consume;
    assign skid_clear = flush | (consume & skid_valid);

    pipe_skid_buf #(.W(EW)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (in_entry),
        .valid_o (skid_valid),
        .data_o  (skid_entry)
    );

    // Main next state: skid has priority over the input so order is preserved
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (consume && skid_valid) begin
            main_d       = skid_entry;
            main_valid_d = 1'b1;
        end else if (accept && (!main_valid_q || consume)) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
        end else if (consume) begin
            main_valid_d = 1'b0;
        end
    end
`else
    // Single entry: ready whenever the slot is empty or draining this cycle
    assign in_ready = ~main_valid_q | out_ready;

    // Main next state: any accept implies the slot is free this cycle
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (accept) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
        end else if (consume) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    // Stall counter next state: count back-pressured cycles, saturating at all ones
    always_comb begin
        cnt_d = cnt_q;
        if (main_valid_q && !out_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State update: reset over flush over normal flow; flush leaves payload and counter alone
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            cnt_q        <= '0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            cnt_q        <= cnt_d;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            cnt_q        <= cnt_d;
        end
    end

    assign {out_ctrl, out_rd, out_data} = main_q;
    assign out_valid = main_valid_q;
    assign out_wen   = main_valid_q & out_ctrl[WEN_BIT];
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

    localparam int N_WORDS = 3;
    localparam int WORD_W  = 32;
    localparam int CTRL_W  = 3;
    localparam int WEN_BIT = 0;
    localparam int RD_W    = 5;
    localparam int CNT_W   = 4;
    localparam int DW      = N_WORDS * WORD_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [RD_W-1:0]   rd;
        logic [DW-1:0]     data;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, out_ready;
    logic              in_ready, out_valid, out_wen;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [RD_W-1:0]   in_rd, out_rd;
    logic [DW-1:0]     in_data, out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int    errors = 0;
    int    checks = 0;
    beat_t mq[$];
    int    mcnt = 0;
    bit    after_rst = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .N_WORDS(N_WORDS), .WORD_W(WORD_W), .CTRL_W(CTRL_W),
        .WEN_BIT(WEN_BIT), .RD_W(RD_W), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .out_wen   (out_wen),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Ready as seen from the held-beat count: one slot frees on consume, two slots need no lookahead
    function automatic bit exp_ready(input bit ordy);
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || ordy;
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = mq.size() > 0;
        check("out_valid", out_valid, ev);
        check("out_wen", out_wen, ev && mq[0].ctrl[WEN_BIT]);
        check("stall_cnt", stall_cnt, mcnt);
        if (ev) begin
            check("out_ctrl", out_ctrl, mq[0].ctrl);
            check("out_rd", out_rd, mq[0].rd);
            check("out_data", out_data, mq[0].data);
        end
        if (after_rst) begin
            check("rst_ctrl", out_ctrl, 0);
            check("rst_rd", out_rd, 0);
            check("rst_data", out_data, 0);
        end
    endtask

    // One clock: drive inputs after the falling edge, step the model at the rising edge, check after the next falling edge
    task automatic cyc(input bit v, input beat_t b, input bit ordy, input bit fl, input bit rst);
        bit acc, cons, stall;
        in_valid  = v;
        in_ctrl   = b.ctrl;
        in_rd     = b.rd;
        in_data   = b.data;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        check("in_ready", in_ready, exp_ready(ordy));
        acc   = v && exp_ready(ordy);
        cons  = (mq.size() > 0) && ordy;
        stall = (mq.size() > 0) && !ordy;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcnt      = 0;
            after_rst = 1;
        end else begin
            after_rst = 0;
            if (stall && mcnt < CNT_MAX) mcnt++;
            if (fl) begin
                mq.delete();
            end else begin
                if (cons) void'(mq.pop_front());
                if (acc) mq.push_back(b);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    function automatic beat_t rnd_beat();
        beat_t b;
        b.ctrl = CTRL_W'($urandom);
        b.rd   = RD_W'($urandom);
        b.data = {$urandom, $urandom, $urandom};
        return b;
    endfunction

    function automatic beat_t mk(input int k);
        beat_t b;
        b.ctrl = 3'b101;
        b.rd   = RD_W'(k);
        b.data = {32'(k * 3 + 2), 32'(k * 3 + 1), 32'(k * 3)};
        return b;
    endfunction

    beat_t z, s;

    initial begin
        z = '0;
        reset = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_ctrl = 0; in_rd = 0; in_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        after_rst = 1;
        check_outputs();
        check("rst_in_ready", in_ready, 1);

        // reset asserted for two cycles in the middle of traffic
        cyc(1, mk(1), 0, 0, 0);
        cyc(1, mk(2), 0, 0, 0);
        cyc(1, mk(3), 0, 0, 1);
        cyc(1, mk(4), 1, 0, 1);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_wen", out_wen, 0);
        check("rst_mid_cnt", stall_cnt, 0);
        cyc(0, z, 1, 0, 0);
        check("rst_ready", in_ready, 1);

        // streaming one beat with known contents
        s.ctrl = 3'b101; s.rd = 5'd8; s.data = {32'h33333333, 32'h22222222, 32'h11111111};
        cyc(1, s, 1, 0, 0);
        check("stream_data", out_data, {32'h33333333, 32'h22222222, 32'h11111111});
        check("stream_rd", out_rd, 8);
        check("stream_wen", out_wen, 1);
        cyc(0, z, 1, 0, 0);

        // back-pressure: three beats offered with out_ready low
        cyc(0, z, 1, 0, 1);
        cyc(1, mk(10), 0, 0, 0);
        cyc(1, mk(11), 0, 0, 0);
        cyc(1, mk(11), 0, 0, 0);
        cyc(1, mk(12), 0, 0, 0);
        cyc(1, mk(12), 0, 0, 0);
        check("bp_stall", stall_cnt, 4);
        repeat (4) cyc(0, z, 1, 0, 0);
        cyc(1, mk(12), 1, 0, 0);
        cyc(0, z, 1, 0, 0);

        // flush while holding a beat and accepting another
        cyc(1, mk(20), 0, 0, 0);
        cyc(1, mk(21), 1, 1, 0);
        check("flush_valid", out_valid, 0);
        check("flush_wen", out_wen, 0);
        repeat (3) cyc(0, z, 1, 0, 0);
        check("flush_gone", out_valid, 0);

        // saturation of the stall counter
        cyc(0, z, 1, 0, 1);
        cyc(1, mk(30), 0, 0, 0);
        repeat (20) cyc(0, z, 0, 0, 0);
        check("sat_cnt", stall_cnt, CNT_MAX);
        cyc(0, z, 0, 0, 0);
        check("sat_hold", stall_cnt, CNT_MAX);
        repeat (2) cyc(0, z, 1, 0, 0);

        // write enable without a valid beat must not reach the register file
        s = mk(40); s.ctrl = 3'b001;
        cyc(0, s, 1, 0, 0);
        check("wen_gate", out_wen, 0);
        cyc(0, s, 0, 0, 0);
        check("wen_gate2", out_wen, 0);

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, rnd_beat(), $urandom_range(0, 9) < 6,
                $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
